// File: rtl/lcd_responder.sv
// Behavioural model of an HD44780-style LCD controller as seen from the host bus:
// synchronises the bus, tracks init sequence, busy timing, DDRAM and control state.
module lcd_responder #(
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned D_15ms   = CLK_FREQ / 1000 * 15,
    parameter int unsigned D_37us   = CLK_FREQ / 1000 * 37 / 1000,
    parameter int unsigned D_1520us = CLK_FREQ / 1000 * 152 / 100
) (
    input  logic       clock,
    input  logic       internal_reset_n,
    input  logic       rs,
    input  logic       e,
    input  logic [7:0] d,
    input  logic [6:0] ddram_rd_addr,
    output logic [7:0] ddram_rd_data,
    output logic       busy,
    output logic       ready,
    output logic [6:0] cursor_addr,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_id,
    output logic       two_line,
    output logic       write_strobe,
    output logic       protocol_error,
    output logic       timing_error
);

    localparam int unsigned CNT_W  = 24;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        ST_POWERUP = 2'd0,
        ST_INIT    = 2'd1,
        ST_READY   = 2'd2
    } state_e;

    function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
        return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    endfunction

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        if (a == 7'h27)      return 7'h40;
        else if (a == 7'h67) return 7'h00;
        else                 return a + ADDR_W'(1);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_dec(input logic [ADDR_W-1:0] a);
        if (a == 7'h00)      return 7'h67;
        else if (a == 7'h40) return 7'h27;
        else                 return a - ADDR_W'(1);
    endfunction

    // Bus synchronisers; e has one extra stage for falling-edge detection
    logic              e_s1_q, e_s2_q, e_s3_q;
    logic              rs_s1_q, rs_s2_q;
    logic [DATA_W-1:0] d_s1_q, d_s2_q;

    always_ff @(posedge clock or negedge internal_reset_n) begin
        if (!internal_reset_n) begin
            e_s1_q  <= 1'b0;
            e_s2_q  <= 1'b0;
            e_s3_q  <= 1'b0;
            rs_s1_q <= 1'b0;
            rs_s2_q <= 1'b0;
            d_s1_q  <= '0;
            d_s2_q  <= '0;
        end else begin
            e_s1_q  <= e;
            e_s2_q  <= e_s1_q;
            e_s3_q  <= e_s2_q;
            rs_s1_q <= rs;
            rs_s2_q <= rs_s1_q;
            d_s1_q  <= d;
            d_s2_q  <= d_s1_q;
        end
    end

    logic wr_evt;
    assign wr_evt = e_s3_q & ~e_s2_q;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        init_cnt_q, init_cnt_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic [ADDR_W-1:0] cursor_q, cursor_d;
    logic              display_on_q, display_on_d;
    logic              cursor_on_q, cursor_on_d;
    logic              blink_on_q, blink_on_d;
    logic              entry_id_q, entry_id_d;
    logic              entry_sh_q, entry_sh_d;
    logic              two_line_q, two_line_d;
    logic              write_strobe_q, write_strobe_d;
    logic              protocol_error_q, protocol_error_d;
    logic              timing_error_q, timing_error_d;
    logic              clr_active_q, clr_active_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] ddram_q [2**ADDR_W];

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        init_cnt_d       = init_cnt_q;
        busy_d           = busy_q;
        ready_d          = ready_q;
        cursor_d         = cursor_q;
        display_on_d     = display_on_q;
        cursor_on_d      = cursor_on_q;
        blink_on_d       = blink_on_q;
        entry_id_d       = entry_id_q;
        entry_sh_d       = entry_sh_q;
        two_line_d       = two_line_q;
        write_strobe_d   = 1'b0;
        protocol_error_d = 1'b0;
        timing_error_d   = 1'b0;
        clr_active_d     = clr_active_q;
        clr_addr_d       = clr_addr_q;
        rd_data_d        = ddram_q[ddram_rd_addr];
        mem_we           = 1'b0;
        mem_addr         = cursor_q;
        mem_wdata        = d_s2_q;

        // Busy countdown; a running Clear fill also holds busy
        if ((state_q != ST_POWERUP) && busy_q) begin
            if (cnt_q != '0)        cnt_d  = cnt_q - CNT_W'(1);
            else if (!clr_active_q) busy_d = 1'b0;
        end

        if (clr_active_q) begin
            mem_we    = 1'b1;
            mem_addr  = clr_addr_q;
            mem_wdata = 8'h20;
            if (clr_addr_q == 7'h67) begin
                clr_active_d = 1'b0;
                cursor_d     = '0;
                entry_id_d   = 1'b1;
            end else begin
                clr_addr_d = addr_inc(clr_addr_q);
            end
        end

        unique case (state_q)
            ST_POWERUP: begin
                if (cnt_q == CNT_W'(D_15ms - 1)) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (wr_evt) timing_error_d = 1'b1;
            end
            ST_INIT: begin
                if (wr_evt) begin
                    if (!rs_s2_q && (d_s2_q[7:4] == 4'b0011)) begin
                        write_strobe_d = 1'b1;
                        init_cnt_d     = init_cnt_q + 2'd1;
                        if (init_cnt_q == 2'd2) begin
                            state_d = ST_READY;
                            ready_d = 1'b1;
                        end
                    end else begin
                        protocol_error_d = 1'b1;
                    end
                end
            end
            ST_READY: begin
                if (wr_evt && busy_q) begin
                    timing_error_d = 1'b1;
                end else if (wr_evt) begin
                    write_strobe_d = 1'b1;
                    busy_d         = 1'b1;
                    cnt_d          = CNT_W'(D_37us - 1);
                    if (rs_s2_q) begin
                        mem_we   = 1'b1;
                        mem_addr = cursor_q;
                        cursor_d = entry_id_q ? addr_inc(cursor_q) : addr_dec(cursor_q);
                    end else if (d_s2_q[7]) begin
                        if (addr_valid(d_s2_q[6:0])) cursor_d = d_s2_q[6:0];
                        else                         protocol_error_d = 1'b1;
                    end else if (d_s2_q[6]) begin
                        // CGRAM address: accepted, no modelled effect
                    end else if (d_s2_q[5]) begin
                        two_line_d = d_s2_q[3];
                    end else if (d_s2_q[4]) begin
                        if (!d_s2_q[3]) cursor_d = d_s2_q[2] ? addr_inc(cursor_q) : addr_dec(cursor_q);
                    end else if (d_s2_q[3]) begin
                        display_on_d = d_s2_q[2];
                        cursor_on_d  = d_s2_q[1];
                        blink_on_d   = d_s2_q[0];
                    end else if (d_s2_q[2]) begin
                        entry_id_d = d_s2_q[1];
                        entry_sh_d = d_s2_q[0];
                    end else if (d_s2_q[1]) begin
                        cursor_d = '0;
                        cnt_d    = CNT_W'(D_1520us - 1);
                    end else if (d_s2_q[0]) begin
                        cnt_d        = CNT_W'(D_1520us - 1);
                        clr_active_d = 1'b1;
                        clr_addr_d   = '0;
                    end
                end
            end
            default: state_d = ST_POWERUP;
        endcase
    end

    always_ff @(posedge clock or negedge internal_reset_n) begin
        if (!internal_reset_n) begin
            state_q          <= ST_POWERUP;
            cnt_q            <= '0;
            init_cnt_q       <= '0;
            busy_q           <= 1'b1;
            ready_q          <= 1'b0;
            cursor_q         <= '0;
            display_on_q     <= 1'b0;
            cursor_on_q      <= 1'b0;
            blink_on_q       <= 1'b0;
            entry_id_q       <= 1'b1;
            entry_sh_q       <= 1'b0;
            two_line_q       <= 1'b0;
            write_strobe_q   <= 1'b0;
            protocol_error_q <= 1'b0;
            timing_error_q   <= 1'b0;
            clr_active_q     <= 1'b0;
            clr_addr_q       <= '0;
            rd_data_q        <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            init_cnt_q       <= init_cnt_d;
            busy_q           <= busy_d;
            ready_q          <= ready_d;
            cursor_q         <= cursor_d;
            display_on_q     <= display_on_d;
            cursor_on_q      <= cursor_on_d;
            blink_on_q       <= blink_on_d;
            entry_id_q       <= entry_id_d;
            entry_sh_q       <= entry_sh_d;
            two_line_q       <= two_line_d;
            write_strobe_q   <= write_strobe_d;
            protocol_error_q <= protocol_error_d;
            timing_error_q   <= timing_error_d;
            clr_active_q     <= clr_active_d;
            clr_addr_q       <= clr_addr_d;
            rd_data_q        <= rd_data_d;
        end
    end

    // DDRAM keeps its contents across reset; invalid-range entries are never written
    always_ff @(posedge clock) begin
        if (mem_we && addr_valid(mem_addr)) ddram_q[mem_addr] <= mem_wdata;
    end

    assign ddram_rd_data  = rd_data_q;
    assign busy           = busy_q;
    assign ready          = ready_q;
    assign cursor_addr    = cursor_q;
    assign display_on     = display_on_q;
    assign cursor_on      = cursor_on_q;
    assign blink_on       = blink_on_q;
    assign entry_id       = entry_id_q;
    assign two_line       = two_line_q;
    assign write_strobe   = write_strobe_q;
    assign protocol_error = protocol_error_q;
    assign timing_error   = timing_error_q;

endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder: init sequence, busy timing, DDRAM writes,
// address wrap, error pulses, Clear/Home and reset abort.
module tb_lcd_responder;

    localparam int unsigned T_PWR   = 200;
    localparam int unsigned T_SHORT = 20;
    localparam int unsigned T_LONG  = 120;

    logic       clock = 1'b0;
    logic       internal_reset_n;
    logic       rs, e;
    logic [7:0] d;
    logic [6:0] ddram_rd_addr;
    logic [7:0] ddram_rd_data;
    logic       busy, ready;
    logic [6:0] cursor_addr;
    logic       display_on, cursor_on, blink_on, entry_id, two_line;
    logic       write_strobe, protocol_error, timing_error;

    lcd_responder #(
        .CLK_FREQ (100000000),
        .D_15ms   (T_PWR),
        .D_37us   (T_SHORT),
        .D_1520us (T_LONG)
    ) dut (
        .clock            (clock),
        .internal_reset_n (internal_reset_n),
        .rs               (rs),
        .e                (e),
        .d                (d),
        .ddram_rd_addr    (ddram_rd_addr),
        .ddram_rd_data    (ddram_rd_data),
        .busy             (busy),
        .ready            (ready),
        .cursor_addr      (cursor_addr),
        .display_on       (display_on),
        .cursor_on        (cursor_on),
        .blink_on         (blink_on),
        .entry_id         (entry_id),
        .two_line         (two_line),
        .write_strobe     (write_strobe),
        .protocol_error   (protocol_error),
        .timing_error     (timing_error)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int n_ws = 0, n_te = 0, n_pe = 0, n_busy = 0;
    int brun = 0, last_brun = 0;

    // Pulse counters and busy run-length, sampled away from the active edge
    always @(negedge clock) begin
        if (write_strobe)   n_ws++;
        if (timing_error)   n_te++;
        if (protocol_error) n_pe++;
        if (busy) begin
            n_busy++;
            brun++;
        end else begin
            if (brun != 0) last_brun = brun;
            brun = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic lcd_wr(input logic r, input logic [7:0] v);
        @(negedge clock);
        rs = r;
        d  = v;
        repeat (2) @(negedge clock);
        e = 1'b1;
        repeat (3) @(negedge clock);
        e = 1'b0;
        repeat (5) @(negedge clock);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 1000) check(tag, 32'(busy), 32'h0);
        @(negedge clock);
    endtask

    task automatic rd(input logic [6:0] a, output logic [7:0] v);
        @(negedge clock);
        ddram_rd_addr = a;
        @(negedge clock);
        v = ddram_rd_data;
    endtask

    initial begin
        int         cnt, ws0, te0, pe0, busy0, bad;
        logic [7:0] v;
        logic [6:0] a;

        internal_reset_n = 1'b0;
        rs = 1'b0; e = 1'b0; d = 8'h00; ddram_rd_addr = 7'h00;
        repeat (3) @(negedge clock);
        check("rst_busy",   32'(busy),          32'h1);
        check("rst_ready",  32'(ready),         32'h0);
        check("rst_cursor", 32'(cursor_addr),   32'h0);
        check("rst_entry",  32'(entry_id),      32'h1);
        check("rst_disp",   32'({display_on, cursor_on, blink_on, two_line}), 32'h0);
        check("rst_rdata",  32'(ddram_rd_data), 32'h0);
        check("rst_pulses", 32'({write_strobe, protocol_error, timing_error}), 32'h0);

        // Power-up wait
        internal_reset_n = 1'b1;
        cnt = 0;
        while (busy && cnt < 1000) begin
            cnt++;
            @(negedge clock);
        end
        check("pwrup_cycles", 32'(cnt),   32'(T_PWR));
        check("pwrup_ready",  32'(ready), 32'h0);

        // Init: non-function-set rejected, then three function sets
        pe0 = n_pe; ws0 = n_ws;
        lcd_wr(1'b1, 8'h41);
        check("init_bad_pe", 32'(n_pe - pe0), 32'h1);
        check("init_bad_ws", 32'(n_ws - ws0), 32'h0);
        ws0 = n_ws; busy0 = n_busy;
        lcd_wr(1'b0, 8'h30);
        lcd_wr(1'b0, 8'h30);
        check("init_ready2", 32'(ready), 32'h0);
        lcd_wr(1'b0, 8'h30);
        check("init_ws",     32'(n_ws - ws0),     32'h3);
        check("init_ready",  32'(ready),          32'h1);
        check("init_nobusy", 32'(n_busy - busy0), 32'h0);
        lcd_wr(1'b0, 8'h38);
        wait_idle("fs_idle");
        check("fs_twoline", 32'(two_line),  32'h1);
        check("fs_busy",    32'(last_brun), 32'(T_SHORT));

        // First character
        ws0 = n_ws;
        lcd_wr(1'b1, 8'h48);
        wait_idle("ch_idle");
        check("ch_ws",     32'(n_ws - ws0), 32'h1);
        check("ch_busy",   32'(last_brun),  32'(T_SHORT));
        check("ch_cursor", 32'(cursor_addr), 32'h01);
        rd(7'h00, v);
        check("ch_ddram",  32'(v), 32'h48);

        // Line-end wraps on increment
        lcd_wr(1'b0, 8'hA7); wait_idle("a7_idle");
        check("set_27", 32'(cursor_addr), 32'h27);
        lcd_wr(1'b1, 8'h41); wait_idle("c41_idle");
        check("wrap_27_40", 32'(cursor_addr), 32'h40);
        rd(7'h27, v);
        check("ddram_27", 32'(v), 32'h41);
        lcd_wr(1'b0, 8'hE7); wait_idle("e7_idle");
        lcd_wr(1'b1, 8'h42); wait_idle("c42_idle");
        check("wrap_67_00", 32'(cursor_addr), 32'h00);
        rd(7'h67, v);
        check("ddram_67", 32'(v), 32'h42);

        // Decrement mode, then a write while busy
        lcd_wr(1'b0, 8'h04); wait_idle("em_idle");
        check("entry_dec", 32'(entry_id), 32'h0);
        lcd_wr(1'b0, 8'h81); wait_idle("81_idle");
        te0 = n_te; ws0 = n_ws;
        lcd_wr(1'b1, 8'h55);
        lcd_wr(1'b1, 8'h66);
        wait_idle("te_idle");
        check("te_pulse",  32'(n_te - te0), 32'h1);
        check("te_ws",     32'(n_ws - ws0), 32'h1);
        check("te_cursor", 32'(cursor_addr), 32'h00);
        rd(7'h00, v);
        check("te_ddram00", 32'(v), 32'h48);
        rd(7'h01, v);
        check("te_ddram01", 32'(v), 32'h55);
        lcd_wr(1'b1, 8'h43); wait_idle("c43_idle");
        check("wrap_00_67", 32'(cursor_addr), 32'h67);

        // Invalid Set-DDRAM
        pe0 = n_pe; ws0 = n_ws;
        lcd_wr(1'b0, 8'hB0); wait_idle("b0_idle");
        check("b0_pe",     32'(n_pe - pe0),  32'h1);
        check("b0_ws",     32'(n_ws - ws0),  32'h1);
        check("b0_cursor", 32'(cursor_addr), 32'h67);
        check("b0_busy",   32'(last_brun),   32'(T_SHORT));

        // Cursor shift, display control, Home
        lcd_wr(1'b0, 8'h14); wait_idle("sh_idle");
        check("shift_inc", 32'(cursor_addr), 32'h00);
        lcd_wr(1'b0, 8'h10); wait_idle("sh2_idle");
        check("shift_dec", 32'(cursor_addr), 32'h67);
        lcd_wr(1'b0, 8'h0D); wait_idle("dc_idle");
        check("disp_ctrl", 32'({display_on, cursor_on, blink_on}), 32'h5);
        lcd_wr(1'b0, 8'h85); wait_idle("85_idle");
        lcd_wr(1'b0, 8'h02); wait_idle("home_idle");
        check("home_cursor", 32'(cursor_addr), 32'h00);
        check("home_busy",   32'(last_brun),   32'(T_LONG));

        // Clear
        lcd_wr(1'b0, 8'h01); wait_idle("clr_idle");
        check("clr_busy",   32'(last_brun),   32'(T_LONG));
        check("clr_cursor", 32'(cursor_addr), 32'h00);
        check("clr_entry",  32'(entry_id),    32'h1);
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            a = (i < 40) ? 7'(i) : 7'(i + 24);
            rd(a, v);
            if (v !== 8'h20) bad++;
        end
        check("clr_fill", 32'(bad), 32'h0);

        // Reset in the middle of a Clear
        lcd_wr(1'b1, 8'h5A); wait_idle("5a_idle");
        lcd_wr(1'b0, 8'h01);
        internal_reset_n = 1'b0;
        #1;
        check("mid_rst_busy",  32'(busy),       32'h1);
        check("mid_rst_ready", 32'(ready),      32'h0);
        check("mid_rst_disp",  32'(display_on), 32'h0);
        @(negedge clock);
        internal_reset_n = 1'b1;
        te0 = n_te; ws0 = n_ws;
        lcd_wr(1'b0, 8'h30);
        check("pwr_te",   32'(n_te - te0), 32'h1);
        check("pwr_ws",   32'(n_ws - ws0), 32'h0);
        check("pwr_busy", 32'(busy),       32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_responder.md
LCD_RESPONDER -- requirements
Module: lcd_responder

Interface
REQ-001 Parameter CLK_FREQ, 100000000, clock frequency in Hz.
REQ-002 Parameter D_15ms, 0.015*CLK_FREQ, power-up wait in cycles.
REQ-003 Parameter D_37us, 0.000037*CLK_FREQ, busy time for data writes and short commands.
REQ-004 Parameter D_1520us, 0.00152*CLK_FREQ, busy time for Clear and Return Home.
REQ-005 clock  in  1  single clock; all state on rising edge.
REQ-006 internal_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-007 rs / e / d  in  1/1/8  LCD bus driven by the host LCD driver; asynchronous to clock.
REQ-008 ddram_rd_addr  in  7  debug read address.
REQ-009 ddram_rd_data  out  8  DDRAM[ddram_rd_addr], registered, 1-cycle latency.
REQ-010 busy  out  1  model busy flag.
REQ-011 ready  out  1  initialisation sequence complete.
REQ-012 cursor_addr  out  7  current DDRAM address counter.
REQ-013 display_on / cursor_on / blink_on / entry_id / two_line  out  1 each  decoded control state.
REQ-014 write_strobe  out  1  one-cycle pulse per accepted bus write.
REQ-015 protocol_error / timing_error  out  1 each  one-cycle error pulses.

Function
REQ-016 e, rs and d SHALL pass through identical 2-FF synchronisers; a write is detected when synced e goes 1->0, capturing synced rs/d from that same cycle.
REQ-017 States: POWERUP, INIT (function-set count 0..3), READY; 24-bit cycle counter.
REQ-018 POWERUP: busy=1; after D_15ms cycles -> INIT, busy=0; any write in POWERUP is ignored and pulses timing_error.
REQ-019 INIT: a write with rs=0, d[7:4]=0011 increments count and pulses write_strobe; busy is not asserted; on third -> READY, ready=1; any other write pulses protocol_error and is ignored.
REQ-020 READY: a write while busy=1 is ignored and pulses timing_error; otherwise it is accepted, write_strobe pulses, and busy rises the next cycle for D_37us cycles (D_1520us for Clear/Home).
REQ-021 rs=1: DDRAM[cursor_addr]<=d, then cursor_addr steps +1 if entry_id=1, else -1.
REQ-022 Address wrap: valid ranges 0x00-0x27 and 0x40-0x67; increment 0x27->0x40, 0x67->0x00; decrement 0x00->0x67, 0x40->0x27.
REQ-023 Command decode, highest set bit of d wins: 0x01 Clear; 0x02-03 Home (cursor_addr=0); 0x04-07 entry_id=d[1], d[0] stored, unused; 0x08-0F display_on=d[2], cursor_on=d[1], blink_on=d[0]; 0x10-1F if d[3]=0 cursor steps per d[2] (1=+1) with wrap, else no-op; 0x20-3F two_line=d[3]; 0x40-7F CGRAM, accepted, no effect; 0x80-FF cursor_addr=d[6:0].
REQ-024 Set-DDRAM to an invalid address (0x28-0x3F, 0x68-0x7F) SHALL pulse protocol_error and leave cursor_addr unchanged, busy still asserted.
REQ-025 Clear SHALL write 0x20 to all 80 valid locations, one per cycle, within the busy window, then set cursor_addr=0, entry_id=1.
REQ-026 DDRAM is 128x8; invalid-range entries are never written.

Reset
REQ-027 On internal_reset_n=0: state=POWERUP, counter=0, busy=1, ready=0, cursor_addr=0, display_on=cursor_on=blink_on=0, entry_id=1, two_line=0, all pulses 0, ddram_rd_data=0; DDRAM contents unchanged.
REQ-028 Reset asserted mid-Clear or mid-busy SHALL abort the operation immediately; partial fill is permitted.

Verification
REQ-029 Release reset, no writes -> busy=1 for exactly D_15ms cycles, then busy=0, ready=0.
REQ-030 Three writes rs=0 d=0x30, then 0x38 -> ready=1 after third, two_line=1, busy high D_37us cycles after 0x38 only.
REQ-031 After init write rs=1 d=0x48 -> DDRAM[0x00]=0x48, cursor_addr=0x01, write_strobe one pulse, busy high D_37us cycles.
REQ-032 Write 0xA7 then char 0x41 -> DDRAM[0x27]=0x41, cursor_addr=0x40; 0xE7 then char -> cursor_addr=0x00.
REQ-033 Char write during busy -> timing_error one cycle, DDRAM and cursor_addr unchanged; write 0xB0 -> protocol_error, cursor_addr unchanged.
REQ-034 Write 0x01 -> all 80 valid locations read 0x20, cursor_addr=0, entry_id=1, busy high D_1520us cycles; reset mid-Clear -> busy=1, state POWERUP.
